// File: rtl/div_unit_if.sv
// Start/ready handshake bundle between the EX stage (master) and the
// multi-cycle divider (slave).
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring shift-subtract divider, one iteration per cycle.
// Result is {remainder, quotient}; signed operands are divided as magnitudes and fixed up at the end.
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;      // dividend shifts out as quotient bits shift in
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic        s1_q, s1_d, s2_q, s2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    // Shifted remainder needs a 33rd bit when the divisor is >= 2^31.
    logic [32:0] rem_sh, diff;
    logic        ge;
    logic [31:0] q_nx, r_nx;

    assign rem_sh = {rem_q, dvd_q[31]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign ge     = rem_sh >= {1'b0, dvs_q};
    assign q_nx   = {dvd_q[30:0], ge};
    assign r_nx   = ge ? diff[31:0] : rem_sh[31:0];

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FREE:   if (!bus.annul_i && bus.start_i)
                           state_d = (bus.opdata2_i == '0) ? ST_BYZERO : ST_ON;
            ST_BYZERO: state_d = bus.annul_i ? ST_FREE : ST_END;
            ST_ON:     if (bus.annul_i)          state_d = ST_FREE;
                       else if (cnt_q == 6'd31)  state_d = ST_END;
            ST_END:    if (bus.annul_i || !bus.start_i) state_d = ST_FREE;
            default:   state_d = ST_FREE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            ST_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (!bus.annul_i && bus.start_i && bus.opdata2_i != '0) begin
                    s1_d  = bus.signed_div_i & bus.opdata1_i[31];
                    s2_d  = bus.signed_div_i & bus.opdata2_i[31];
                    dvd_d = s1_d ? -bus.opdata1_i : bus.opdata1_i;
                    dvs_d = s2_d ? -bus.opdata2_i : bus.opdata2_i;
                    rem_d = '0;
                    cnt_d = '0;
                end
            end
            ST_BYZERO: begin
                ready_d  = !bus.annul_i;
                result_d = '0;
            end
            ST_ON: begin
                if (bus.annul_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    dvd_d = q_nx;
                    rem_d = r_nx;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        // Quotient truncates toward zero; remainder follows the dividend sign.
                        result_d = {s1_q ? -r_nx : r_nx, (s1_q ^ s2_q) ? -q_nx : q_nx};
                        ready_d  = 1'b1;
                    end
                end
            end
            ST_END: begin
                if (bus.annul_i || !bus.start_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: driver pushes expected results into a queue,
// a negedge monitor pops and checks value and latency on each ready_o rise.
module tb_div_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if bus();
    div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.ready_o === 1'b1 && !prev_rdy) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got result %h expected no ready", bus.result_o);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_result"}, bus.result_o, e.res);
                check({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end
        prev_rdy = (bus.ready_o === 1'b1);
    end

    task automatic do_op(input string nm, input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input bit rst_in_end);
        bit got;
        @(negedge clk);
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        sbq.push_back('{exp, lat, cyc + 1, nm});
        @(negedge clk);
        // Operands change after acceptance; the result must not care.
        bus.signed_div_i = ~sg;
        bus.opdata1_i    = ~a ^ 32'h5a5a1234;
        bus.opdata2_i    = b + 32'd3;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.ready_o === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", nm);
            if (sbq.size() != 0) void'(sbq.pop_back());
            bus.start_i = 1'b0;
            @(negedge clk);
            return;
        end
        repeat (2) begin
            @(negedge clk);
            check({nm, "_hold"}, {bus.ready_o, bus.result_o}, {1'b1, exp});
        end
        if (rst_in_end) begin
            #2 rst = 1'b0;
            #1 check({nm, "_async_rst"}, {bus.ready_o, bus.result_o}, 65'd0);
            bus.start_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end else begin
            bus.start_i = 1'b0;
            @(negedge clk);
            check({nm, "_drop"}, {bus.ready_o, bus.result_o}, 65'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {bus.ready_o, bus.result_o}, 65'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {bus.ready_o, bus.result_o}, 65'd0);

        do_op("u_100_7",      1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},               32, 1'b0);
        do_op("s_m7_2",       1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD},  32, 1'b0);
        do_op("u_m7_2",       1'b0, 32'hFFFFFFF9,  32'd2,         {32'd1, 32'h7FFFFFFC},         32, 1'b0);
        do_op("u_div0",       1'b0, 32'd1234,      32'd0,         64'h0,                         1,  1'b0);
        do_op("s_div0",       1'b1, 32'hFFFFFFFB,  32'd0,         64'h0,                         1,  1'b0);
        do_op("s_min_m1",     1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000},         32, 1'b0);
        do_op("s_7_m2",       1'b1, 32'd7,         32'hFFFFFFFE,  {32'd1, 32'hFFFFFFFD},         32, 1'b0);
        do_op("s_m100_m7",    1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE, 32'd14},        32, 1'b0);
        do_op("u_max_msb",    1'b0, 32'hFFFFFFFF,  32'h80000000,  {32'h7FFFFFFF, 32'd1},         32, 1'b0);
        do_op("u_5_10",       1'b0, 32'd5,         32'd10,        {32'd5, 32'd0},                32, 1'b0);

        // Annul at iteration 10, then a new operation two cycles later.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (9) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        check("annul_no_ready", {63'd0, bus.ready_o}, 64'd0);
        do_op("u_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 32, 1'b0);

        // Reset while a result is being presented.
        do_op("u_200_9", 1'b0, 32'd200, 32'd9, {32'd2, 32'd22}, 32, 1'b1);

        // Reset mid-ON between edges, then a fresh operation.
        @(negedge clk);
        bus.opdata1_i = 32'd77;
        bus.opdata2_i = 32'd4;
        bus.start_i   = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        bus.start_i = 1'b0;
        #1 check("rst_mid_on", {bus.ready_o, bus.result_o}, 65'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_op("u_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 1'b0);

        repeat (40) @(negedge clk);
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
